// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master core among NREQ requesters with burst locking.
// Define SPI_ARBITER_RR_EN for round-robin arbitration; otherwise lowest index wins.
module spi_arbiter #(
  parameter int NREQ = 2,
  parameter int D_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_cont,
  input  logic [NREQ*D_WIDTH-1:0] req_tx,
  input  logic [NREQ*2-1:0]       req_mode,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [D_WIDTH-1:0]      rx_data,
  output logic                    core_enable,
  output logic                    core_cont,
  output logic                    core_cpol,
  output logic                    core_cpha,
  output logic [D_WIDTH-1:0]      core_tx_data,
  input  logic                    core_busy,
  input  logic [D_WIDTH-1:0]      core_rx_data
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, START, XFER, DONE, HOLD} state_t;
  state_t state, state_d;
  logic [IW-1:0] g, win, ptr;
  logic [NREQ-1:0] one_hot;
  int k;
  // Scan from the highest offset down so the last hit is the first set bit at or after ptr.
  always_comb begin
    win = '0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k]) win = IW'(k);
    end
    one_hot = '0;
    one_hot[win] = 1'b1;
  end
`ifdef SPI_ARBITER_RR_EN
  logic rel;
  assign rel = (state == DONE && !core_cont) || (state == HOLD && !req[g]);
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (rel) ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
`else
  assign ptr = '0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = |req ? START : IDLE;
      START:   state_d = core_enable && core_busy ? XFER : START;
      XFER:    state_d = core_busy ? XFER : DONE;
      DONE:    state_d = core_cont ? HOLD : IDLE;
      HOLD:    state_d = req[g] ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign done = state == DONE ? gnt : '0;
  // core_cont doubles as the latched "burst continues" flag for the current byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      g <= '0;
      gnt <= '0;
      rx_data <= '0;
      core_enable <= 1'b0;
      core_cont <= 1'b0;
      core_cpol <= 1'b0;
      core_cpha <= 1'b0;
      core_tx_data <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (|req) begin
          g <= win;
          gnt <= one_hot;
          core_tx_data <= req_tx[int'(win)*D_WIDTH +: D_WIDTH];
          {core_cpha, core_cpol} <= req_mode[int'(win)*2 +: 2];
          core_cont <= req_cont[win];
        end
        START: core_enable <= !(core_enable && core_busy);
        XFER: if (!core_busy) rx_data <= core_rx_data;
        DONE: if (!core_cont) gnt <= '0;
        HOLD: if (req[g]) begin
          core_tx_data <= req_tx[int'(g)*D_WIDTH +: D_WIDTH];
          core_cont <= req_cont[g];
        end else begin
          gnt <= '0;
          core_cont <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural SPI core (rx = tx ^ 8'h99).
module tb_spi_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = '0, req_cont = '0;
  logic [7:0] tx0 = '0, tx1 = '0;
  logic [1:0] mode0 = '0, mode1 = '0;
  logic [15:0] req_tx;
  logic [3:0] req_mode;
  logic [1:0] gnt, done;
  logic [7:0] rx_data, core_tx_data, core_rx_data, tx_cap;
  logic core_enable, core_cont, core_cpol, core_cpha, core_busy;
  logic [1:0] cap_mode;
  logic cap_cont;
  int cnt;
  assign req_tx = {tx1, tx0};
  assign req_mode = {mode1, mode0};

  spi_arbiter #(.NREQ(2), .D_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cont(req_cont), .req_tx(req_tx),
    .req_mode(req_mode), .gnt(gnt), .done(done), .rx_data(rx_data),
    .core_enable(core_enable), .core_cont(core_cont), .core_cpol(core_cpol),
    .core_cpha(core_cpha), .core_tx_data(core_tx_data), .core_busy(core_busy),
    .core_rx_data(core_rx_data)
  );

  always #5 clk = ~clk;

  // Core: busy one edge after enable is seen, stays busy 8 cycles, returns tx ^ 8'h99.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy <= 1'b0;
      cnt <= 0;
      core_rx_data <= '0;
      tx_cap <= '0;
      cap_mode <= '0;
      cap_cont <= 1'b0;
    end else if (core_busy) begin
      if (cnt == 1) begin
        core_busy <= 1'b0;
        core_rx_data <= tx_cap ^ 8'h99;
      end
      cnt <= cnt - 1;
    end else if (core_enable) begin
      core_busy <= 1'b1;
      cnt <= 8;
      tx_cap <= core_tx_data;
      cap_mode <= {core_cpha, core_cpol};
      cap_cont <= core_cont;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {logic [1:0] d; logic [7:0] rx; logic [1:0] mode; logic cont;} exp_t;
  exp_t q[$];
  task automatic push(input logic [1:0] d, input logic [7:0] rx, input logic [1:0] m, input logic c);
    exp_t e;
    e.d = d;
    e.rx = rx;
    e.mode = m;
    e.cont = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && done != 2'b00) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=%b with nothing expected", done);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_vec", 32'(done), 32'(e.d));
        chk("gnt_at_done", 32'(gnt), 32'(e.d));
        chk("rx_data", 32'(rx_data), 32'(e.rx));
        chk("core_mode_seen", 32'(cap_mode), 32'(e.mode));
        chk("core_cont_seen", 32'(cap_cont), 32'(e.cont));
      end
    end
  end

  logic in_burst = 1'b0;
  int lock_bad = 0;
  always @(negedge clk) if (in_burst && gnt !== 2'b10) lock_bad++;

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (done == 2'b00 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done != 2'b00), 1);
  endtask

  task automatic wait_busy();
    int t = 0;
    @(negedge clk);
    while (!core_busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("busy_seen", 32'(core_busy), 1);
  endtask

  task automatic wait_idle(output int en);
    int t = 0;
    en = 0;
    while (gnt != 2'b00 && t < 300) begin
      en += int'(core_enable);
      @(negedge clk);
      t++;
    end
    chk("idle_seen", 32'(gnt), 0);
  endtask

  int en, bad;
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rx", 32'(rx_data), 0);
    chk("rst_enable", 32'(core_enable), 0);
    chk("rst_cont", 32'(core_cont), 0);
    chk("rst_mode", 32'({core_cpha, core_cpol}), 0);
    chk("rst_tx", 32'(core_tx_data), 0);
    reset = 1'b0;
    @(negedge clk);
    // Single byte from requester 0
    tx0 = 8'hA5; mode0 = 2'b10; req_cont = 2'b00; req = 2'b01;
    push(2'b01, 8'h3C, 2'b10, 1'b0);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_tx", 32'(core_tx_data), 32'hA5);
    chk("single_cpha", 32'(core_cpha), 1);
    chk("single_cpol", 32'(core_cpol), 0);
    chk("single_en_first_cycle", 32'(core_enable), 0);
    req = 2'b00;
    @(negedge clk);
    chk("single_en_rise", 32'(core_enable), 1);
    wait_idle(en);
    chk("single_en_cycles", 32'(en), 2);
    // Burst lock on requester 1 while requester 0 waits
    tx1 = 8'h22; mode1 = 2'b01; req_cont = 2'b10; req = 2'b10;
    push(2'b10, 8'hBB, 2'b01, 1'b1);
    @(negedge clk);
    chk("burst_gnt", 32'(gnt), 32'h2);
    tx0 = 8'h11; mode0 = 2'b00; req[0] = 1'b1;
    in_burst = 1'b1;
    wait_done();
    push(2'b10, 8'hAA, 2'b01, 1'b1);
    tx1 = 8'h33; mode1 = 2'b10;
    wait_done();
    push(2'b10, 8'hDD, 2'b01, 1'b0);
    tx1 = 8'h44; req_cont[1] = 1'b0;
    wait_done();
    in_burst = 1'b0;
    req[1] = 1'b0;
    push(2'b01, 8'h88, 2'b00, 1'b0);
    @(negedge clk);
    chk("burst_gap_gnt", 32'(gnt), 0);
    chk("burst_gap_cont", 32'(core_cont), 0);
    @(negedge clk);
    chk("burst_next_gnt", 32'(gnt), 32'h1);
    chk("burst_next_tx", 32'(core_tx_data), 32'h11);
    req = 2'b00;
    wait_idle(en);
    chk("burst_lock_held", 32'(lock_bad), 0);
    // Contention with both requesting single bytes
    tx0 = 8'h55; tx1 = 8'h66; req_cont = 2'b00; req = 2'b11;
`ifdef SPI_ARBITER_RR_EN
    push(2'b10, 8'hFF, 2'b10, 1'b0);
`else
    push(2'b01, 8'hCC, 2'b00, 1'b0);
`endif
    push(2'b01, 8'hCC, 2'b00, 1'b0);
    wait_done();
    wait_done();
    req = 2'b00;
    wait_idle(en);
    // Lock abandon: continue requested, then request dropped in HOLD
    tx0 = 8'h77; req_cont = 2'b01; req = 2'b01;
    push(2'b01, 8'hEE, 2'b00, 1'b1);
    wait_done();
    req = 2'b00;
    @(negedge clk);
    chk("abandon_hold_gnt", 32'(gnt), 32'h1);
    chk("abandon_hold_cont", 32'(core_cont), 1);
    @(negedge clk);
    chk("abandon_gnt", 32'(gnt), 0);
    chk("abandon_cont", 32'(core_cont), 0);
    en = 0;
    repeat (10) begin
      @(negedge clk);
      en += int'(core_enable);
    end
    chk("abandon_no_enable", 32'(en), 0);
    // Early drop during XFER still completes
    tx0 = 8'h5A; req_cont = 2'b00; req = 2'b01;
    push(2'b01, 8'hC3, 2'b00, 1'b0);
    wait_busy();
    req = 2'b00;
    wait_idle(en);
    chk("early_rx_held", 32'(rx_data), 32'hC3);
    // Reset while the core is busy
    tx1 = 8'h0F; req_cont = 2'b10; req = 2'b10;
    wait_busy();
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_enable", 32'(core_enable), 0);
    chk("mid_rst_cont", 32'(core_cont), 0);
    chk("mid_rst_rx", 32'(rx_data), 0);
    req = 2'b00; req_cont = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (gnt != 2'b00 || core_enable) bad++;
    end
    chk("post_rst_idle", 32'(bad), 0);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
